// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg: shared widths, access codes and state encodings for the
// byte-serial data memory controller.
package data_mem_ctrl_pkg;

    localparam int DATA_BUS_W      = 32;
    localparam int DATA_ADDR_BUS_W = 32;

    // Access direction on LSRW
    localparam logic LS_READ  = 1'b0;
    localparam logic LS_WRITE = 1'b1;

    // Generic strobe levels
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // Size codes on LSlen (both 10 and 11 mean a 4-byte access)
    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;

    typedef enum logic [1:0] {
        DMC_IDLE      = 2'd0,
        DMC_WRITE     = 2'd1,
        DMC_READ      = 2'd2,
        DMC_READ_TAIL = 2'd3
    } dmc_state_t;

    // Index of the last byte of an access (N-1)
    function automatic logic [1:0] last_idx(input logic [1:0] len);
        case (len)
            LEN_BYTE: last_idx = 2'd0;
            LEN_HALF: last_idx = 2'd1;
            default:  last_idx = 2'd3;
        endcase
    endfunction

    // True when the address is not a multiple of the access size
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] len);
        case (len)
            LEN_BYTE: is_misaligned = 1'b0;
            LEN_HALF: is_misaligned = addr_lo[0];
            default:  is_misaligned = |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: load/store request bus plus the byte-wide RAM port.
//
// Handshake: dataEn is the request valid and LSfree the ready; a request is
// transferred on a posedge where both are 1. The controller then owns the RAM
// port until it raises LSoutEn for exactly one cycle; Ldata and misAlign are
// meaningful only in that cycle. LSfree is 1 again in the LSoutEn cycle, so
// a new request may be transferred on the edge that ends it.
interface data_mem_ctrl_if;
    import data_mem_ctrl_pkg::*;

    logic                       dataEn;
    logic                       LSRW;
    logic [DATA_ADDR_BUS_W-1:0] dataAddr;
    logic [1:0]                 LSlen;
    logic [DATA_BUS_W-1:0]      Sdata;
    logic                       LSoutEn;
    logic [DATA_BUS_W-1:0]      Ldata;
    logic                       LSfree;
    logic [7:0]                 memIn;
    logic [7:0]                 memOut;
    logic [DATA_ADDR_BUS_W-1:0] memAddr;
    logic                       memWr;
    logic                       misAlign;

    // Controller side
    modport slave (
        input  dataEn, LSRW, dataAddr, LSlen, Sdata, memIn,
        output LSoutEn, Ldata, LSfree, memOut, memAddr, memWr, misAlign
    );

    // Load/store unit and RAM side
    modport master (
        output dataEn, LSRW, dataAddr, LSlen, Sdata, memIn,
        input  LSoutEn, Ldata, LSfree, memOut, memAddr, memWr, misAlign
    );

endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: serialises 1/2/4-byte loads and stores onto a byte-wide
// synchronous RAM (read data returns one cycle after the address).
// Optional feature: define DMC_ALIGN_CHECK_EN to flag misaligned accesses on
// misAlign alongside LSoutEn; otherwise misAlign is tied to 0.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    data_mem_ctrl_if.slave    ls,
    output dmc_state_t        dbg_state
);

    dmc_state_t                 state_q, state_n;
    logic [1:0]                 k_q, k_n;
    logic [1:0]                 last_q, last_n;
    logic [23:0]                sdata_hi_q, sdata_hi_n;
    logic [DATA_ADDR_BUS_W-1:0] addr_q, addr_n;
    logic                       wr_q, wr_n;
    logic [7:0]                 out_q, out_n;
    logic [DATA_BUS_W-1:0]      ldata_q, ldata_n;
    logic                       done_q, done_n;

    // State and all registered outputs; reset aborts any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= DMC_IDLE;
            k_q        <= 2'd0;
            last_q     <= 2'd0;
            sdata_hi_q <= 24'h0;
            addr_q     <= '0;
            wr_q       <= DISABLE;
            out_q      <= 8'h00;
            ldata_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            k_q        <= k_n;
            last_q     <= last_n;
            sdata_hi_q <= sdata_hi_n;
            addr_q     <= addr_n;
            wr_q       <= wr_n;
            out_q      <= out_n;
            ldata_q    <= ldata_n;
            done_q     <= done_n;
        end
    end

    // Next state, byte steering and RAM port values for the coming cycle
    always_comb begin
        state_n    = state_q;
        k_n        = k_q;
        last_n     = last_q;
        sdata_hi_n = sdata_hi_q;
        addr_n     = addr_q;
        wr_n       = DISABLE;
        out_n      = 8'h00;
        ldata_n    = ldata_q;
        done_n     = 1'b0;

        case (state_q)
            DMC_IDLE: begin
                addr_n = '0;
                k_n    = 2'd0;
                if (ls.dataEn == ENABLE) begin
                    last_n     = last_idx(ls.LSlen);
                    sdata_hi_n = ls.Sdata[31:8];
                    addr_n     = ls.dataAddr;
                    // Stores report zero; loads build up from zero
                    ldata_n    = '0;
                    if (ls.LSRW == LS_READ) begin
                        state_n = DMC_READ;
                    end else begin
                        state_n = DMC_WRITE;
                        wr_n    = ENABLE;
                        out_n   = ls.Sdata[7:0];
                    end
                end
            end

            DMC_WRITE: begin
                if (k_q == last_q) begin
                    state_n = DMC_IDLE;
                    addr_n  = '0;
                    k_n     = 2'd0;
                    done_n  = 1'b1;
                end else begin
                    k_n    = k_q + 2'd1;
                    addr_n = addr_q + 32'd1;
                    wr_n   = ENABLE;
                    case (k_n)
                        2'd1:    out_n = sdata_hi_q[7:0];
                        2'd2:    out_n = sdata_hi_q[15:8];
                        default: out_n = sdata_hi_q[23:16];
                    endcase
                end
            end

            DMC_READ: begin
                // memIn now carries the byte addressed one cycle earlier
                case (k_q)
                    2'd1:    ldata_n[7:0]   = ls.memIn;
                    2'd2:    ldata_n[15:8]  = ls.memIn;
                    2'd3:    ldata_n[23:16] = ls.memIn;
                    default: ;
                endcase
                if (k_q == last_q) begin
                    // Hold the address; the final byte arrives next cycle
                    state_n = DMC_READ_TAIL;
                end else begin
                    k_n    = k_q + 2'd1;
                    addr_n = addr_q + 32'd1;
                end
            end

            DMC_READ_TAIL: begin
                case (last_q)
                    2'd0:    ldata_n = {24'h0, ls.memIn};
                    2'd1:    ldata_n = {16'h0, ls.memIn, ldata_q[7:0]};
                    default: ldata_n = {ls.memIn, ldata_q[23:0]};
                endcase
                state_n = DMC_IDLE;
                addr_n  = '0;
                k_n     = 2'd0;
                done_n  = 1'b1;
            end

            default: begin
                state_n = DMC_IDLE;
                addr_n  = '0;
                k_n     = 2'd0;
            end
        endcase
    end

`ifdef DMC_ALIGN_CHECK_EN
    logic mis_lat_q;
    logic mis_q;

    // Capture alignment at request time and present it with the completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_lat_q <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            if (state_q == DMC_IDLE && ls.dataEn == ENABLE) begin
                mis_lat_q <= is_misaligned(ls.dataAddr[1:0], ls.LSlen);
            end
            mis_q <= done_n & mis_lat_q;
        end
    end

    assign ls.misAlign = mis_q;
`else
    assign ls.misAlign = 1'b0;
`endif

    assign ls.LSoutEn = done_q;
    assign ls.Ldata   = ldata_q;
    assign ls.LSfree  = (state_q == DMC_IDLE);
    assign ls.memOut  = out_q;
    assign ls.memAddr = addr_q;
    assign ls.memWr   = wr_q;
    assign dbg_state  = state_q;

endmodule
